// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: resolves branches/jumps, pulses a one-cycle PC redirect
// and squashes the wrong-path instruction. Optional skid buffer under EXMEM_SKID_EN.
module ex_mem_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [5:0]      ex_alu_ctrl,
   input  logic [XLEN-1:0] ex_alu_out,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic [REGW-1:0] ex_rd,
   input  logic            ex_reg_we,
   input  logic            ex_mem_re,
   input  logic            ex_mem_we,
   input  logic            ex_is_jal,
   input  logic            ex_is_jalr,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [XLEN-1:0] mem_result,
   output logic [XLEN-1:0] mem_store_data,
   output logic [REGW-1:0] mem_rd,
   output logic            mem_reg_we,
   output logic            mem_re,
   output logic            mem_we,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam int PW = 2*XLEN + REGW + 3;

   logic            r_mem_valid;
   logic [PW-1:0]   r_out;
   logic            r_redirect_valid;
   logic [XLEN-1:0] r_redirect_pc;

   logic            w_accept;
   logic            w_take;
   logic            w_is_branch;
   logic            w_taken_br;
   logic            w_is_jump;
   logic            w_redirect;
   logic            w_out_free;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_result;
   logic [PW-1:0]   w_payload;

   always_comb begin
      w_is_branch = 1'b0;
      case (ex_alu_ctrl)
         6'd9, 6'd10, 6'd11, 6'd12, 6'd14, 6'd15: w_is_branch = 1'b1;
         default:                                 w_is_branch = 1'b0;
      endcase
   end

   // An instruction handshaken during the redirect cycle is the wrong-path one: consume, drop.
   assign w_accept   = ex_valid & ex_ready;
   assign w_take     = w_accept & ~r_redirect_valid;
   assign w_taken_br = w_is_branch & ex_alu_out[30];
   assign w_is_jump  = ex_is_jal | ex_is_jalr;
   assign w_redirect = w_take & (w_taken_br | w_is_jump);
   assign w_target   = ex_is_jalr ? {ex_alu_out[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
   assign w_result   = w_is_jump ? ex_pc + XLEN'(4) : ex_alu_out;
   assign w_out_free = ~r_mem_valid | mem_ready;

   assign w_payload = {w_result, ex_rs2_data, ex_rd,
                       ex_reg_we & ~w_is_branch,
                       ex_mem_re & ~w_is_branch,
                       ex_mem_we & ~w_is_branch};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_redirect;
         if (w_redirect) r_redirect_pc <= w_target;
      end
   end

`ifdef EXMEM_SKID_EN
   logic          r_skid_valid;
   logic [PW-1:0] r_skid;

   // ready depends only on registered state, so mem_ready never reaches ex_ready.
   assign ex_ready = rst_n & (~r_skid_valid | r_redirect_valid);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_valid  <= 1'b0;
         r_out        <= '0;
         r_skid_valid <= 1'b0;
         r_skid       <= '0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_mem_valid  <= 1'b1;
            r_out        <= r_skid;
            r_skid_valid <= w_take;
            if (w_take) r_skid <= w_payload;
         end else begin
            r_mem_valid <= w_take;
            if (w_take) r_out <= w_payload;
         end
      end else if (w_take) begin
         r_skid_valid <= 1'b1;
         r_skid       <= w_payload;
      end
   end
`else
   assign ex_ready = rst_n & (~r_mem_valid | mem_ready | r_redirect_valid);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_out_free) begin
         r_mem_valid <= w_take;
         if (w_take) r_out <= w_payload;
      end
   end
`endif

   assign mem_valid      = r_mem_valid;
   assign mem_result     = r_out[PW-1 -: XLEN];
   assign mem_store_data = r_out[XLEN+REGW+2 -: XLEN];
   assign mem_rd         = r_out[REGW+2 -: REGW];
   assign mem_reg_we     = r_out[2];
   assign mem_re         = r_out[1];
   assign mem_we         = r_out[0];
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases, stall burst, reset-over-redirect
// and a random phase, all checked against a scoreboard of expected MEM payloads and redirects.
module tb_ex_mem_stage;

   localparam int XLEN = 32;
   localparam int REGW = 5;
   localparam int PW   = 2*XLEN + REGW + 3;

   logic            clk;
   logic            rst_n;
   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_imm;
   logic [5:0]      ex_alu_ctrl;
   logic [XLEN-1:0] ex_alu_out;
   logic [XLEN-1:0] ex_rs2_data;
   logic [REGW-1:0] ex_rd;
   logic            ex_reg_we;
   logic            ex_mem_re;
   logic            ex_mem_we;
   logic            ex_is_jal;
   logic            ex_is_jalr;
   logic            mem_valid;
   logic            mem_ready;
   logic [XLEN-1:0] mem_result;
   logic [XLEN-1:0] mem_store_data;
   logic [REGW-1:0] mem_rd;
   logic            mem_reg_we;
   logic            mem_re;
   logic            mem_we;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   ex_mem_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_alu_ctrl    (ex_alu_ctrl),
      .ex_alu_out     (ex_alu_out),
      .ex_rs2_data    (ex_rs2_data),
      .ex_rd          (ex_rd),
      .ex_reg_we      (ex_reg_we),
      .ex_mem_re      (ex_mem_re),
      .ex_mem_we      (ex_mem_we),
      .ex_is_jal      (ex_is_jal),
      .ex_is_jalr     (ex_is_jalr),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_result     (mem_result),
      .mem_store_data (mem_store_data),
      .mem_rd         (mem_rd),
      .mem_reg_we     (mem_reg_we),
      .mem_re         (mem_re),
      .mem_we         (mem_we),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [PW-1:0]   exp_q[$];
   logic [XLEN-1:0] redir_q[$];
   logic            exp_redir_now = 1'b0;
   logic            rnd_on = 1'b0;

   task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic is_br(input logic [5:0] c);
      return (c == 6'd9) || (c == 6'd10) || (c == 6'd11) || (c == 6'd12) ||
             (c == 6'd14) || (c == 6'd15);
   endfunction

   function automatic logic [PW-1:0] model_payload();
      logic [XLEN-1:0] res;
      logic            br;
      br  = is_br(ex_alu_ctrl);
      res = (ex_is_jal || ex_is_jalr) ? ex_pc + 32'd4 : ex_alu_out;
      return {res, ex_rs2_data, ex_rd, ex_reg_we & ~br, ex_mem_re & ~br, ex_mem_we & ~br};
   endfunction

   // Monitor: inputs change just after posedge, so negedge sees what the next edge will see.
   always @(negedge clk) begin
      logic            acc;
      logic            squash;
      logic            xfer;
      logic [XLEN-1:0] tgt;
      chk("redir_valid", redirect_valid, exp_redir_now);
      if (redirect_valid) begin
         chk("redir_q_avail", redir_q.size() > 0, 1'b1);
         if (redir_q.size() > 0) chk("redir_pc", redirect_pc, redir_q.pop_front());
      end
      if (mem_valid && mem_ready) begin
         chk("exp_q_avail", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0)
            chk("payload", {mem_result, mem_store_data, mem_rd, mem_reg_we, mem_re, mem_we},
                exp_q.pop_front());
      end
      if (!rst_n) begin
         exp_q.delete();
         redir_q.delete();
         exp_redir_now = 1'b0;
      end else begin
         acc    = ex_valid && ex_ready;
         squash = exp_redir_now;
         xfer   = (is_br(ex_alu_ctrl) && ex_alu_out[30]) || ex_is_jal || ex_is_jalr;
         tgt    = ex_is_jalr ? (ex_alu_out & 32'hFFFF_FFFE) : ex_pc + ex_imm;
         exp_redir_now = acc && !squash && xfer;
         if (acc && !squash) begin
            exp_q.push_back(model_payload());
            if (xfer) redir_q.push_back(tgt);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [5:0] ctrl, input logic [XLEN-1:0] alu,
                       input logic [REGW-1:0] rd, input logic we, input logic re,
                       input logic mwe, input logic jal, input logic jalr);
      logic done;
      done        = 1'b0;
      ex_valid    = 1'b1;
      ex_pc       = pc;
      ex_imm      = imm;
      ex_alu_ctrl = ctrl;
      ex_alu_out  = alu;
      ex_rs2_data = $urandom;
      ex_rd       = rd;
      ex_reg_we   = we;
      ex_mem_re   = re;
      ex_mem_we   = mwe;
      ex_is_jal   = jal;
      ex_is_jalr  = jalr;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (ex_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      ex_valid = 1'b0;
      chk("send_accept", done, 1'b1);
   endtask

   task automatic send_alu(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                           input logic [REGW-1:0] rd);
      send(pc, 32'd0, 6'd0, alu, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      ex_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [5:0] ctrl_tab [8];

   initial begin
      ctrl_tab = '{6'd0, 6'd1, 6'd9, 6'd10, 6'd11, 6'd12, 6'd14, 6'd15};
      rst_n       = 1'b0;
      mem_ready   = 1'b1;
      ex_valid    = 1'b1;
      ex_pc       = 32'h80;
      ex_imm      = 32'h40;
      ex_alu_ctrl = 6'd0;
      ex_alu_out  = 32'h1234;
      ex_rs2_data = 32'h5;
      ex_rd       = 5'd3;
      ex_reg_we   = 1'b1;
      ex_mem_re   = 1'b0;
      ex_mem_we   = 1'b0;
      ex_is_jal   = 1'b1;
      ex_is_jalr  = 1'b0;

      // reset with an instruction presented
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_redir_valid", redirect_valid, 1'b0);
      chk("rst_redir_pc", redirect_pc, 32'd0);
      chk("rst_mem_result", mem_result, 32'd0);
      chk("rst_ex_ready", ex_ready, 1'b0);
      rst_n     = 1'b1;
      ex_valid  = 1'b0;
      ex_is_jal = 1'b0;
      idle(1);

      // plain ALU op, one-cycle latency
      send_alu(32'h10, 32'h0000_0010, 5'd5);
      chk("alu_mem_valid", mem_valid, 1'b1);
      chk("alu_result", mem_result, 32'h10);
      chk("alu_rd", mem_rd, 5'd5);
      chk("alu_reg_we", mem_reg_we, 1'b1);
      idle(2);

      // taken beq followed by a wrong-path instruction
      send(32'h100, 32'hFFFF_FFF0, 6'd9, 32'h4000_0000, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("beq_redir_valid", redirect_valid, 1'b1);
      chk("beq_redir_pc", redirect_pc, 32'hF0);
      chk("beq_enables", {mem_reg_we, mem_re, mem_we}, 3'b000);
      send_alu(32'h104, 32'h77, 5'd7);
      chk("squash_redir_clear", redirect_valid, 1'b0);
      chk("squash_no_payload", mem_valid, 1'b0);
      idle(2);

      // not-taken bne, next instruction flows
      send(32'h110, 32'h40, 6'd10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bne_no_redir", redirect_valid, 1'b0);
      send_alu(32'h114, 32'h55, 5'd9);
      chk("bne_next_valid", mem_valid, 1'b1);
      chk("bne_next_result", mem_result, 32'h55);
      idle(2);

      // jumps
      send(32'h200, 32'h0, 6'd0, 32'h0000_0345, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("jalr_redir_pc", redirect_pc, 32'h344);
      chk("jalr_result", mem_result, 32'h204);
      idle(2);
      send(32'h300, 32'h20, 6'd0, 32'hDEAD, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("jal_redir_pc", redirect_pc, 32'h320);
      chk("jal_result", mem_result, 32'h304);
      idle(2);

      // three-instruction burst against a three-cycle output stall
      mem_ready = 1'b0;
      fork
         begin
            send_alu(32'h400, 32'hA1, 5'd10);
            send_alu(32'h404, 32'hA2, 5'd11);
`ifdef EXMEM_SKID_EN
            chk("skid_full_ready", ex_ready, 1'b0);
`endif
            send_alu(32'h408, 32'hA3, 5'd12);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            chk("stall_hold", mem_result, 32'hA1);
            @(posedge clk);
            #1;
            mem_ready = 1'b1;
         end
      join
      idle(4);

      // reset lands on a redirect cycle while the output is stalled
      mem_ready = 1'b0;
      send(32'h500, 32'h100, 6'd11, 32'h4000_0000, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rstmid_redir_before", redirect_valid, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rstmid_redir_cleared", redirect_valid, 1'b0);
      chk("rstmid_mem_valid", mem_valid, 1'b0);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      idle(1);
      chk("rstmid_no_pulse", redirect_valid, 1'b0);
      idle(1);

      // random traffic with random back-pressure
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               mem_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join_none
      for (int k = 0; k < 300; k++) begin
         logic [5:0]      c;
         logic [XLEN-1:0] a;
         int              j;
         if ($urandom_range(0, 9) < 2) begin
            idle(1);
         end else begin
            j = $urandom_range(0, 9);
            c = (j < 2) ? 6'd0 : ctrl_tab[$urandom_range(0, 7)];
            a = is_br(c) ? ($urandom_range(0, 1) ? 32'h4000_0000 : 32'h0) : $urandom;
            send($urandom, $urandom, c, a, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 j == 0, j == 1);
         end
      end
      rnd_on = 1'b0;
      idle(1);
      mem_ready = 1'b1;
      idle(6);

      chk("exp_q_empty", exp_q.size(), 0);
      chk("redir_q_empty", redir_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
